// File: rtl/vdp_reg_write_arbiter_pkg.sv
// Shared source encodings, default widths and the round-robin pick helper for the VDP
// register-write arbiter.
package vdp_reg_write_arbiter_pkg;

    localparam logic SRC_HOST   = 1'b0;
    localparam logic SRC_COPPER = 1'b1;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 6;
    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    // Winner when both slots are pending: whichever source was not granted last.
    function automatic logic rr_pick(input logic last_grant);
        return (last_grant == SRC_HOST) ? SRC_COPPER : SRC_HOST;
    endfunction

endpackage

// File: rtl/vdp_reg_arb_slot.sv
// One-entry holding slot for a single write source; it accepts a strobe when it is empty
// or is being drained this cycle, and otherwise flags the strobe as dropped.
module vdp_reg_arb_slot
    import vdp_reg_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  strobe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  grant,
    output logic                  pending,
    output logic                  ready,
    output logic                  drop,
    output logic [ADDR_WIDTH-1:0] slot_addr,
    output logic [DATA_WIDTH-1:0] slot_data
);

    logic                  full_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    assign ready     = !full_q || grant;
    assign drop      = strobe && !ready;
    assign pending   = full_q;
    assign slot_addr = addr_q;
    assign slot_data = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (strobe && ready) begin
            // A grant in the same cycle hands off the old entry while this one refills.
            full_q <= 1'b1;
            addr_q <= addr;
            data_q <= data;
        end else if (grant) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// Arbitrates host and copper writes onto the single VDP register-file write port.
// Define VDP_REG_ARB_COPPER_PRIORITY_EN for fixed copper priority; default is round-robin.
module vdp_reg_write_arbiter
    import vdp_reg_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_write_en,
    input  logic [ADDR_WIDTH-1:0] host_write_address,
    input  logic [DATA_WIDTH-1:0] host_write_data,
    output logic                  host_write_ready,
    input  logic                  copper_write_en,
    input  logic [ADDR_WIDTH-1:0] copper_write_address,
    input  logic [DATA_WIDTH-1:0] copper_write_data,
    output logic                  copper_write_ready,
    output logic                  reg_write_en,
    output logic [ADDR_WIDTH-1:0] reg_write_address,
    output logic [DATA_WIDTH-1:0] reg_write_data,
    input  logic                  reg_write_ready,
    output logic [1:0]            overflow,
    input  logic                  overflow_clear
);

    logic                  host_pending, copper_pending;
    logic                  host_drop, copper_drop;
    logic                  grant_host, grant_copper;
    logic                  out_free;
    logic [1:0]            overflow_d;
    logic [ADDR_WIDTH-1:0] host_slot_addr, copper_slot_addr;
    logic [DATA_WIDTH-1:0] host_slot_data, copper_slot_data;

    vdp_reg_arb_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_host_slot (
        .clk       (clk),
        .reset     (reset),
        .strobe    (host_write_en),
        .addr      (host_write_address),
        .data      (host_write_data),
        .grant     (grant_host),
        .pending   (host_pending),
        .ready     (host_write_ready),
        .drop      (host_drop),
        .slot_addr (host_slot_addr),
        .slot_data (host_slot_data)
    );

    vdp_reg_arb_slot #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_copper_slot (
        .clk       (clk),
        .reset     (reset),
        .strobe    (copper_write_en),
        .addr      (copper_write_address),
        .data      (copper_write_data),
        .grant     (grant_copper),
        .pending   (copper_pending),
        .ready     (copper_write_ready),
        .drop      (copper_drop),
        .slot_addr (copper_slot_addr),
        .slot_data (copper_slot_data)
    );

    assign out_free = !reg_write_en || reg_write_ready;

`ifndef VDP_REG_ARB_COPPER_PRIORITY_EN
    logic last_grant_q;
`endif

    always_comb begin
        grant_host   = 1'b0;
        grant_copper = 1'b0;
        if (out_free) begin
`ifdef VDP_REG_ARB_COPPER_PRIORITY_EN
            if (copper_pending) begin
                grant_copper = 1'b1;
            end else if (host_pending) begin
                grant_host = 1'b1;
            end
`else
            if (host_pending && copper_pending) begin
                grant_copper = (rr_pick(last_grant_q) == SRC_COPPER);
                grant_host   = (rr_pick(last_grant_q) == SRC_HOST);
            end else begin
                grant_copper = copper_pending;
                grant_host   = host_pending;
            end
`endif
        end
    end

    // A drop in the same cycle as a clear still leaves its bit set.
    assign overflow_d = (overflow_clear ? 2'b00 : overflow) | {copper_drop, host_drop};

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_en      <= 1'b0;
            reg_write_address <= '0;
            reg_write_data    <= '0;
            overflow          <= 2'b00;
        end else begin
            if (grant_copper) begin
                reg_write_en      <= 1'b1;
                reg_write_address <= copper_slot_addr;
                reg_write_data    <= copper_slot_data;
            end else if (grant_host) begin
                reg_write_en      <= 1'b1;
                reg_write_address <= host_slot_addr;
                reg_write_data    <= host_slot_data;
            end else if (reg_write_ready) begin
                reg_write_en <= 1'b0;
            end
            overflow <= overflow_d;
        end
    end

`ifndef VDP_REG_ARB_COPPER_PRIORITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= SRC_HOST;
        end else if (grant_copper) begin
            last_grant_q <= SRC_COPPER;
        end else if (grant_host) begin
            last_grant_q <= SRC_HOST;
        end
    end
`endif

endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// Directed bench for vdp_reg_write_arbiter with a per-cycle reference model and literal checks.
module tb_vdp_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_write_en = 1'b0;
    logic [5:0]  host_write_address = '0;
    logic [15:0] host_write_data = '0;
    logic        host_write_ready;
    logic        copper_write_en = 1'b0;
    logic [5:0]  copper_write_address = '0;
    logic [15:0] copper_write_data = '0;
    logic        copper_write_ready;
    logic        reg_write_en;
    logic [5:0]  reg_write_address;
    logic [15:0] reg_write_data;
    logic        reg_write_ready = 1'b1;
    logic [1:0]  overflow;
    logic        overflow_clear = 1'b0;

    always #5 clk = ~clk;

    vdp_reg_write_arbiter dut (
        .clk                  (clk),
        .reset                (reset),
        .host_write_en        (host_write_en),
        .host_write_address   (host_write_address),
        .host_write_data      (host_write_data),
        .host_write_ready     (host_write_ready),
        .copper_write_en      (copper_write_en),
        .copper_write_address (copper_write_address),
        .copper_write_data    (copper_write_data),
        .copper_write_ready   (copper_write_ready),
        .reg_write_en         (reg_write_en),
        .reg_write_address    (reg_write_address),
        .reg_write_data       (reg_write_data),
        .reg_write_ready      (reg_write_ready),
        .overflow             (overflow),
        .overflow_clear       (overflow_clear)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each source holds at most one write, the port holds at most one.
    bit          m_live = 1'b0;
    bit          m_h_full, m_c_full, m_out_v, m_last_copper;
    logic [5:0]  m_h_a, m_c_a, m_out_a;
    logic [15:0] m_h_d, m_c_d, m_out_d;
    logic [1:0]  m_ovf;

    logic [21:0] emit_q[$];
    int          emit_cyc[$];

    function automatic void pick(output bit gh, output bit gc);
        gh = 1'b0;
        gc = 1'b0;
        if (m_out_v && !reg_write_ready) return;
`ifdef VDP_REG_ARB_COPPER_PRIORITY_EN
        if (m_c_full) gc = 1'b1;
        else if (m_h_full) gh = 1'b1;
`else
        if (m_c_full && m_h_full) begin
            if (m_last_copper) gh = 1'b1;
            else gc = 1'b1;
        end else if (m_c_full) gc = 1'b1;
        else if (m_h_full) gh = 1'b1;
`endif
    endfunction

    always @(posedge clk) begin : model
        bit gh, gc, hr, cr;
        cyc++;
        if (reset) begin
            m_live = 1'b1;
            m_h_full = 1'b0; m_c_full = 1'b0; m_out_v = 1'b0; m_last_copper = 1'b0;
            m_h_a = '0; m_c_a = '0; m_out_a = '0;
            m_h_d = '0; m_c_d = '0; m_out_d = '0;
            m_ovf = 2'b00;
        end else begin
            pick(gh, gc);
            hr = !m_h_full || gh;
            cr = !m_c_full || gc;
            if (gc) begin
                m_out_v = 1'b1; m_out_a = m_c_a; m_out_d = m_c_d;
                m_c_full = 1'b0; m_last_copper = 1'b1;
            end else if (gh) begin
                m_out_v = 1'b1; m_out_a = m_h_a; m_out_d = m_h_d;
                m_h_full = 1'b0; m_last_copper = 1'b0;
            end else if (reg_write_ready) begin
                m_out_v = 1'b0;
            end
            if (overflow_clear) m_ovf = 2'b00;
            if (host_write_en) begin
                if (hr) begin
                    m_h_full = 1'b1; m_h_a = host_write_address; m_h_d = host_write_data;
                end else m_ovf[0] = 1'b1;
            end
            if (copper_write_en) begin
                if (cr) begin
                    m_c_full = 1'b1; m_c_a = copper_write_address; m_c_d = copper_write_data;
                end else m_ovf[1] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit gh, gc;
        if (m_live) begin
            pick(gh, gc);
            check("model reg_write_en", 32'(reg_write_en), 32'(m_out_v));
            if (m_out_v) begin
                check("model reg_write_address", 32'(reg_write_address), 32'(m_out_a));
                check("model reg_write_data", 32'(reg_write_data), 32'(m_out_d));
            end
            check("model host_write_ready", 32'(host_write_ready), 32'(!m_h_full || gh));
            check("model copper_write_ready", 32'(copper_write_ready), 32'(!m_c_full || gc));
            check("model overflow", 32'(overflow), 32'(m_ovf));
            if (!reset && reg_write_en && reg_write_ready) begin
                emit_q.push_back({reg_write_address, reg_write_data});
                emit_cyc.push_back(cyc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected to finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic en, input logic [5:0] a, input logic [15:0] d);
        host_write_en = en; host_write_address = a; host_write_data = d;
    endtask

    task automatic cop_wr(input logic en, input logic [5:0] a, input logic [15:0] d);
        copper_write_en = en; copper_write_address = a; copper_write_data = d;
    endtask

    task automatic check_out(input string name, input logic [5:0] a, input logic [15:0] d);
        check({name, " en"}, 32'(reg_write_en), 32'h1);
        check({name, " addr"}, 32'(reg_write_address), 32'(a));
        check({name, " data"}, 32'(reg_write_data), 32'(d));
    endtask

    initial begin : stimulus
        int base;
        logic [5:0]  first_a, second_a;
        logic [15:0] first_d, second_d;

        repeat (3) step();
        reset = 1'b0;
        check("reset reg_write_en", 32'(reg_write_en), 32'h0);
        check("reset host_ready", 32'(host_write_ready), 32'h1);
        check("reset copper_ready", 32'(copper_write_ready), 32'h1);
        check("reset overflow", 32'(overflow), 32'h0);

        // Single host write on an idle path: output appears two cycles later for one cycle.
        reg_write_ready = 1'b1;
        host_wr(1'b1, 6'h05, 16'hBEEF);
        step();
        host_wr(1'b0, '0, '0);
        check("idle N+1 en", 32'(reg_write_en), 32'h0);
        step();
        check_out("idle N+2", 6'h05, 16'hBEEF);
        step();
        check("idle N+3 en", 32'(reg_write_en), 32'h0);
        check("idle overflow", 32'(overflow), 32'h0);

        // Simultaneous strobes after a host grant: copper first.
        host_wr(1'b1, 6'h01, 16'h1111);
        cop_wr(1'b1, 6'h02, 16'h2222);
        step();
        host_wr(1'b0, '0, '0);
        cop_wr(1'b0, '0, '0);
        step();
        check_out("tie1 first", 6'h02, 16'h2222);
        step();
        check_out("tie1 second", 6'h01, 16'h1111);
        step();
        check("tie1 drained", 32'(reg_write_en), 32'h0);

        // Tie after a copper grant: round-robin favours host, fixed priority keeps copper.
        cop_wr(1'b1, 6'h03, 16'h3333);
        step();
        cop_wr(1'b0, '0, '0);
        repeat (3) step();
        host_wr(1'b1, 6'h04, 16'h4444);
        cop_wr(1'b1, 6'h05, 16'h5555);
        step();
        host_wr(1'b0, '0, '0);
        cop_wr(1'b0, '0, '0);
        step();
`ifdef VDP_REG_ARB_COPPER_PRIORITY_EN
        first_a = 6'h05; first_d = 16'h5555; second_a = 6'h04; second_d = 16'h4444;
`else
        first_a = 6'h04; first_d = 16'h4444; second_a = 6'h05; second_d = 16'h5555;
`endif
        check_out("tie2 first", first_a, first_d);
        step();
        check_out("tie2 second", second_a, second_d);
        step();

        // Stall: copper strobes every two cycles while the register file refuses writes.
        base = emit_q.size();
        reg_write_ready = 1'b0;
        cop_wr(1'b1, 6'h10, 16'hA0A0);
        step();
        cop_wr(1'b0, '0, '0);
        check("stall S1 copper_ready", 32'(copper_write_ready), 32'h1);
        step();
        check_out("stall S2 hold", 6'h10, 16'hA0A0);
        check("stall S2 copper_ready", 32'(copper_write_ready), 32'h1);
        cop_wr(1'b1, 6'h11, 16'hA1A1);
        step();
        cop_wr(1'b0, '0, '0);
        check("stall S3 copper_ready", 32'(copper_write_ready), 32'h0);
        check_out("stall S3 hold", 6'h10, 16'hA0A0);
        step();
        cop_wr(1'b1, 6'h12, 16'hA2A2);
        step();
        cop_wr(1'b0, '0, '0);
        check("stall overflow", 32'(overflow), 32'h2);
        check_out("stall S5 hold", 6'h10, 16'hA0A0);
        step();
        reg_write_ready = 1'b1;
        check_out("drain first", 6'h10, 16'hA0A0);
        step();
        check_out("drain second", 6'h11, 16'hA1A1);
        step();
        check("drain done en", 32'(reg_write_en), 32'h0);
        check("drain count", 32'(emit_q.size() - base), 32'h2);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        check("stall overflow cleared", 32'(overflow), 32'h0);

        // Host strobes every cycle: eight writes out back-to-back, no drops.
        base = emit_q.size();
        for (int i = 0; i < 8; i++) begin
            host_wr(1'b1, 6'h20 + 6'(i), 16'h1000 + 16'(i));
            check("burst host_ready", 32'(host_write_ready), 32'h1);
            step();
        end
        host_wr(1'b0, '0, '0);
        repeat (3) step();
        check("burst count", 32'(emit_q.size() - base), 32'h8);
        if (emit_q.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                logic [21:0] exp_w;
                exp_w = {6'h20 + 6'(i), 16'h1000 + 16'(i)};
                check("burst order", 32'(emit_q[base + i]), 32'(exp_w));
                check("burst spacing", 32'(emit_cyc[base + i] - emit_cyc[base]), 32'(i));
            end
        end
        check("burst overflow", 32'(overflow), 32'h0);

        // A drop and a clear in the same cycle: the drop wins.
        reg_write_ready = 1'b0;
        host_wr(1'b1, 6'h30, 16'h3000);
        step();
        host_wr(1'b1, 6'h31, 16'h3001);
        step();
        check("dropclr host_ready", 32'(host_write_ready), 32'h0);
        host_wr(1'b1, 6'h32, 16'h3002);
        overflow_clear = 1'b1;
        step();
        host_wr(1'b0, '0, '0);
        check("dropclr set wins", 32'(overflow), 32'h1);
        step();
        overflow_clear = 1'b0;
        check("dropclr clear alone", 32'(overflow), 32'h0);
        base = emit_q.size();
        reg_write_ready = 1'b1;
        repeat (4) step();
        check("dropclr drain count", 32'(emit_q.size() - base), 32'h2);
        if (emit_q.size() >= base + 2) begin
            check("dropclr drain 0", 32'(emit_q[base]), 32'({6'h30, 16'h3000}));
            check("dropclr drain 1", 32'(emit_q[base + 1]), 32'({6'h31, 16'h3001}));
        end

        // Reset mid-handshake with both slots full: nothing stale ever emerges.
        reg_write_ready = 1'b0;
        host_wr(1'b1, 6'h38, 16'h3838);
        step();
        host_wr(1'b1, 6'h39, 16'h3939);
        cop_wr(1'b1, 6'h3A, 16'h3A3A);
        step();
        host_wr(1'b0, '0, '0);
        cop_wr(1'b0, '0, '0);
        check_out("prereset out", 6'h38, 16'h3838);
        check("prereset host_ready", 32'(host_write_ready), 32'h0);
        check("prereset copper_ready", 32'(copper_write_ready), 32'h0);
        reset = 1'b1;
        reg_write_ready = 1'b1;
        step();
        reset = 1'b0;
        check("postreset en", 32'(reg_write_en), 32'h0);
        check("postreset host_ready", 32'(host_write_ready), 32'h1);
        check("postreset copper_ready", 32'(copper_write_ready), 32'h1);
        check("postreset overflow", 32'(overflow), 32'h0);
        base = emit_q.size();
        repeat (6) step();
        check("postreset no stale writes", 32'(emit_q.size() - base), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
